// File: rtl/nios_system_pio_out_pkg.sv
// Shared definitions for the output PIO: register map, CTRL/STATUS bits and pulse FSM states.
package nios_system_pio_out_pkg;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned BUS_W  = 32;

    localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_MASK     = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_LEN      = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_CTRL     = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_OUTSET   = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_OUTCLEAR = 3'd5;

    localparam int unsigned CTRL_START_BIT  = 0;
    localparam int unsigned STATUS_BUSY_BIT = 0;
    localparam int unsigned STATUS_DONE_BIT = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        PULSE = 1'b1
    } pulse_state_e;

endpackage

// File: rtl/nios_system_pio_out_pulse.sv
// One-shot pulse timer: a start with a non-zero length holds busy for exactly len cycles.
// done_set is a same-cycle strobe marking the final pulse cycle so the sticky flag lines up with busy falling.
module nios_system_pio_out_pulse
    import nios_system_pio_out_pkg::*;
#(
    parameter int unsigned CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    output logic             busy,
    output logic             done_set
);

    pulse_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    // A start with zero length is ignored in either state; otherwise it (re)loads the counter.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_set = 1'b0;
        if (start && (len != '0)) begin
            state_d = PULSE;
            cnt_d   = len;
            busy_d  = 1'b1;
        end else if (state_q == PULSE) begin
            if (cnt_q == CNT_W'(1)) begin
                state_d  = IDLE;
                cnt_d    = '0;
                busy_d   = 1'b0;
                done_set = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/nios_system_pio_out.sv
// Avalon-MM output PIO with register-backed out_port and a one-shot pulse timer XORing a mask on top.
// Optional atomic OUTSET/OUTCLEAR registers are built when PIO_OUT_BITSET_EN is defined.
module nios_system_pio_out
    import nios_system_pio_out_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned      CNT_W       = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [BUS_W-1:0]  writedata,
    output logic [BUS_W-1:0]  readdata,
    output logic [WIDTH-1:0]  out_port
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [BUS_W-1:0] readdata_q, readdata_d;

    logic wr;
    logic ctrl_wr;
    logic start;
    logic busy;
    logic done_set;
    logic unused_wd;

    assign wr        = chipselect & ~write_n;
    assign ctrl_wr   = wr && (address == ADDR_CTRL);
    assign start     = ctrl_wr && writedata[CTRL_START_BIT];
    assign unused_wd = ^writedata;

    nios_system_pio_out_pulse #(
        .CNT_W (CNT_W)
    ) u_pulse (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .len      (len_q),
        .busy     (busy),
        .done_set (done_set)
    );

    // Register file writes
    always_comb begin
        data_d = data_q;
        mask_d = mask_q;
        len_d  = len_q;
        if (wr) begin
            case (address)
                ADDR_DATA:     data_d = writedata[WIDTH-1:0];
                ADDR_MASK:     mask_d = writedata[WIDTH-1:0];
                ADDR_LEN:      len_d  = writedata[CNT_W-1:0];
`ifdef PIO_OUT_BITSET_EN
                ADDR_OUTSET:   data_d = data_q | writedata[WIDTH-1:0];
                ADDR_OUTCLEAR: data_d = data_q & ~writedata[WIDTH-1:0];
`endif
                default: ;
            endcase
        end
    end

    // Sticky done: any CTRL write clears it, completion of a pulse sets it.
    always_comb begin
        done_d = done_q;
        if (ctrl_wr) begin
            done_d = 1'b0;
        end
        if (done_set) begin
            done_d = 1'b1;
        end
    end

    always_comb begin
        out_d = data_q ^ (busy ? mask_q : '0);
    end

    // Read mux, registered every cycle from the current address
    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA: readdata_d = BUS_W'(data_q);
            ADDR_MASK: readdata_d = BUS_W'(mask_q);
            ADDR_LEN:  readdata_d = BUS_W'(len_q);
            ADDR_CTRL: begin
                readdata_d[STATUS_BUSY_BIT] = busy;
                readdata_d[STATUS_DONE_BIT] = done_q;
            end
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q     <= RESET_VALUE;
            mask_q     <= '0;
            len_q      <= '0;
            done_q     <= 1'b0;
            out_q      <= RESET_VALUE;
            readdata_q <= '0;
        end else begin
            data_q     <= data_d;
            mask_q     <= mask_d;
            len_q      <= len_d;
            done_q     <= done_d;
            out_q      <= out_d;
            readdata_q <= readdata_d;
        end
    end

    assign out_port = out_q;
    assign readdata = readdata_q;

endmodule

// File: tb/tb_nios_system_pio_out.sv
// Bench for nios_system_pio_out with RESET_VALUE=8'hA5: expected values are queued as stimulus is driven
// and popped after each clock edge.
module tb_nios_system_pio_out;

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int errors = 0;
    int checks = 0;

    logic [31:0] rd_q[$];
    logic [7:0]  out_q[$];

    nios_system_pio_out #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5),
        .CNT_W       (24)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = '0;
    endtask

    task automatic drive_write(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
    endtask

    task automatic drive_read(input logic [2:0] a);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        writedata  = '0;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        drive_write(a, d);
        tick();
        drive_idle();
    endtask

    task automatic test_reset();
        logic [31:0] e;
        reset = 1'b1;
        drive_idle();
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (out_port !== 8'hA5) begin
            errors++;
            $display("FAIL reset_out_port: got %h want a5", out_port);
        end
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_readdata: got %h want 0", readdata);
        end
        drive_read(3'd0);
        rd_q.push_back(32'h0000_00A5);
        tick();
        e = rd_q.pop_front();
        checks++;
        if (readdata !== e) begin
            errors++;
            $display("FAIL reset_read_data: got %h want %h", readdata, e);
        end
        drive_idle();
    endtask

    task automatic test_data_write();
        logic [7:0]  eo;
        logic [31:0] e;
        drive_write(3'd0, 32'hFFFF_FF3C);
        out_q.push_back(8'hA5);
        tick();
        drive_idle();
        eo = out_q.pop_front();
        checks++;
        if (out_port !== eo) begin
            errors++;
            $display("FAIL data_out_edge_n: got %h want %h", out_port, eo);
        end
        out_q.push_back(8'h3C);
        tick();
        eo = out_q.pop_front();
        checks++;
        if (out_port !== eo) begin
            errors++;
            $display("FAIL data_out_edge_n1: got %h want %h", out_port, eo);
        end
        drive_read(3'd0);
        rd_q.push_back(32'h0000_003C);
        tick();
        e = rd_q.pop_front();
        checks++;
        if (readdata !== e) begin
            errors++;
            $display("FAIL data_readback: got %h want %h", readdata, e);
        end
        drive_idle();
    endtask

    task automatic test_bitset();
        logic [7:0]  eo;
        logic [31:0] e;
        bus_write(3'd0, 32'h0000_00F0);
        bus_write(3'd4, 32'h0000_000F);
        bus_write(3'd5, 32'h0000_0081);
`ifdef PIO_OUT_BITSET_EN
        out_q.push_back(8'h7E);
`else
        out_q.push_back(8'hF0);
`endif
        tick();
        tick();
        eo = out_q.pop_front();
        checks++;
        if (out_port !== eo) begin
            errors++;
            $display("FAIL bitset_out: got %h want %h", out_port, eo);
        end
        drive_read(3'd4);
        rd_q.push_back(32'h0);
        tick();
        e = rd_q.pop_front();
        checks++;
        if (readdata !== e) begin
            errors++;
            $display("FAIL outset_read_zero: got %h want %h", readdata, e);
        end
        drive_read(3'd7);
        rd_q.push_back(32'h0);
        tick();
        e = rd_q.pop_front();
        checks++;
        if (readdata !== e) begin
            errors++;
            $display("FAIL addr7_read_zero: got %h want %h", readdata, e);
        end
        drive_idle();
    endtask

    // Issues a start at k=0 (and optionally again at restart_k), otherwise polls STATUS.
    // Pulse/busy expected over k=1..t; t=0 means no pulse at all.
    task automatic run_pulse(input string nm, input int restart_k, input int ncyc, input int t,
                             input logic [31:0] rd0);
        logic [7:0]  eo;
        logic [31:0] e;
        for (int k = 0; k < ncyc; k++) begin
            if (k == 0 || k == restart_k) drive_write(3'd3, 32'h1);
            else drive_read(3'd3);
            out_q.push_back((k >= 1 && k <= t) ? 8'h01 : 8'h00);
            if (k == 0) rd_q.push_back(rd0);
            else if (k <= t) rd_q.push_back(32'h1);
            else if (t > 0) rd_q.push_back(32'h2);
            else rd_q.push_back(32'h0);
            tick();
            eo = out_q.pop_front();
            e  = rd_q.pop_front();
            checks++;
            if (out_port !== eo) begin
                errors++;
                $display("FAIL %s_out_k%0d: got %h want %h", nm, k, out_port, eo);
            end
            checks++;
            if (readdata !== e) begin
                errors++;
                $display("FAIL %s_status_k%0d: got %h want %h", nm, k, readdata, e);
            end
        end
        drive_idle();
    endtask

    task automatic test_pulse();
        logic [31:0] e;
        bus_write(3'd0, 32'h0);
        bus_write(3'd1, 32'h01);
        bus_write(3'd2, 32'h5);
        tick();
        drive_read(3'd2);
        rd_q.push_back(32'h5);
        tick();
        e = rd_q.pop_front();
        checks++;
        if (readdata !== e) begin
            errors++;
            $display("FAIL len_readback: got %h want %h", readdata, e);
        end
        run_pulse("pulse5", -1, 9, 5, 32'h0);
    endtask

    task automatic test_len_zero();
        bus_write(3'd2, 32'h0);
        // previous pulse left done=1; the start write clears it without starting anything
        run_pulse("len0", -1, 5, 0, 32'h2);
    endtask

    task automatic test_restart();
        bus_write(3'd2, 32'h5);
        run_pulse("restart", 3, 11, 8, 32'h0);
    endtask

    task automatic test_reset_mid_pulse();
        logic [31:0] e;
        drive_write(3'd3, 32'h1);
        tick();
        drive_idle();
        tick();
        checks++;
        if (out_port !== 8'h01) begin
            errors++;
            $display("FAIL midreset_pulse_active: got %h want 01", out_port);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (out_port !== 8'hA5) begin
            errors++;
            $display("FAIL midreset_out_edge: got %h want a5", out_port);
        end
        drive_read(3'd3);
        rd_q.push_back(32'h0);
        tick();
        e = rd_q.pop_front();
        checks++;
        if (readdata !== e) begin
            errors++;
            $display("FAIL midreset_status: got %h want %h", readdata, e);
        end
        checks++;
        if (out_port !== 8'hA5) begin
            errors++;
            $display("FAIL midreset_out_later: got %h want a5", out_port);
        end
        drive_read(3'd1);
        rd_q.push_back(32'h0);
        tick();
        e = rd_q.pop_front();
        checks++;
        if (readdata !== e) begin
            errors++;
            $display("FAIL midreset_mask: got %h want %h", readdata, e);
        end
        drive_idle();
    endtask

    initial begin
        reset = 1'b1;
        drive_idle();
        test_reset();
        test_data_write();
        test_bitset();
        test_pulse();
        test_len_zero();
        test_restart();
        test_reset_mid_pulse();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
